// File: rtl/hci_core_per_bridge_if.sv
// hci_core request/response bundle as seen by the peripheral bridge.
// Carries one request channel (req/gnt) and one response channel (r_valid).
interface hci_core_intf #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32,
  parameter int unsigned UW = 1
) ();

  logic              req;
  logic              gnt;
  logic [AW-1:0]     add;
  logic              wen;
  logic [DW-1:0]     data;
  logic [DW/8-1:0]   be;
  logic [DW/8-1:0]   boffs;
  logic [UW-1:0]     user;
  logic              lrdy;
  logic [DW-1:0]     r_data;
  logic              r_valid;
  logic [UW-1:0]     r_user;
  logic              r_opc;

  modport master (
    output req, add, wen, data, be, boffs, user, lrdy,
    input  gnt, r_data, r_valid, r_user, r_opc
  );

  modport slave (
    input  req, add, wen, data, be, boffs, user, lrdy,
    output gnt, r_data, r_valid, r_user, r_opc
  );

endinterface

// File: rtl/hci_core_per_bridge.sv
// Peripheral bridge: turns the filter's hci_core request stream into a
// single-outstanding req/gnt/r_valid peripheral bus. Every granted request
// produces exactly one registered slave response, including an error response
// when the peripheral fails to grant or respond within TIMEOUT cycles.
package hci_package;
  localparam int unsigned DEFAULT_AW = 32;
  localparam int unsigned DEFAULT_DW = 32;
  localparam int unsigned DEFAULT_UW = 1;
endpackage

module hci_core_per_bridge
  import hci_package::*;
#(
  parameter int unsigned AW       = DEFAULT_AW,
  parameter int unsigned DW       = DEFAULT_DW,
  parameter int unsigned UW       = DEFAULT_UW,
  parameter int unsigned TIMEOUT  = 256,
  parameter logic [31:0] ERR_DATA = 32'hbadacce5
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clear_i,
  hci_core_intf.slave     slave,
  output logic            per_req_o,
  input  logic            per_gnt_i,
  output logic [AW-1:0]   per_add_o,
  output logic            per_wen_o,
  output logic [DW-1:0]   per_data_o,
  output logic [DW/8-1:0] per_be_o,
  output logic [UW-1:0]   per_user_o,
  input  logic            per_r_valid_i,
  input  logic [DW-1:0]   per_r_data_i,
  input  logic            per_r_opc_i,
  output logic            busy_o,
  output logic            timeout_o
);

  localparam int unsigned   BW       = DW / 8;
  localparam int unsigned   CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [DW-1:0] ERR_WORD = DW'(ERR_DATA);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_RSP,
    S_RSP,
    S_ERR
  } state_e;

  state_e          r_state;
  state_e          w_next;
  logic [CW-1:0]   r_cnt;
  logic [AW-1:0]   r_add;
  logic            r_wen;
  logic [DW-1:0]   r_data;
  logic [BW-1:0]   r_be;
  logic [UW-1:0]   r_user;
  logic [DW-1:0]   r_rsp_data;
  logic            r_rsp_opc;
  logic [UW-1:0]   r_rsp_user;
  logic            w_expired;
  logic            w_capture;
  logic            w_unused;

  // Byte offset and lrdy have no meaning on a single-beat peripheral bus.
  assign w_unused = ^{slave.boffs, slave.lrdy};

  // The last counted cycle with no progress ends the transaction in ERR.
  assign w_expired = (TIMEOUT != 0) && (r_cnt == CNT_LAST);

  // Response capture, including the zero-latency gnt+r_valid case in REQ.
  assign w_capture = ((r_state == S_REQ) && per_gnt_i && per_r_valid_i) ||
                     ((r_state == S_WAIT_RSP) && per_r_valid_i);

  // Next-state decode; a progress event always beats the timeout.
  always_comb begin
    // NOTE: default first so every path assigns w_next and no latch is inferred.
    w_next = r_state;
    unique case (r_state)
      S_IDLE:     if (slave.req) w_next = S_REQ;
      S_REQ: begin
        if (per_gnt_i)      w_next = per_r_valid_i ? S_RSP : S_WAIT_RSP;
        else if (w_expired) w_next = S_ERR;
      end
      S_WAIT_RSP: begin
        if (per_r_valid_i)  w_next = S_RSP;
        else if (w_expired) w_next = S_ERR;
      end
      S_RSP:      w_next = S_IDLE;
      S_ERR:      w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // State, timeout counter, latched request and captured response.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst_i || clear_i) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_add      <= '0;
      r_wen      <= 1'b0;
      r_data     <= '0;
      r_be       <= '0;
      r_user     <= '0;
      r_rsp_data <= '0;
      r_rsp_opc  <= 1'b0;
      r_rsp_user <= '0;
    end else begin
      r_state <= w_next;
      // Held at zero while idle, so counting starts from zero on REQ entry.
      if (r_state == S_IDLE)
        r_cnt <= '0;
      else if ((r_state == S_REQ) || (r_state == S_WAIT_RSP))
        r_cnt <= r_cnt + 1'b1;
      if ((r_state == S_IDLE) && slave.req) begin
        r_add  <= slave.add;
        r_wen  <= slave.wen;
        r_data <= slave.data;
        r_be   <= slave.be;
        r_user <= slave.user;
      end
      if (w_capture) begin
        r_rsp_data <= per_r_data_i;
        r_rsp_opc  <= per_r_opc_i;
        r_rsp_user <= r_user;
      end
    end
  end

  // Slave response driven from registers only; zero outside RSP/ERR.
  always_comb begin
    slave.r_valid = 1'b0;
    slave.r_data  = '0;
    slave.r_opc   = 1'b0;
    slave.r_user  = '0;
    if (r_state == S_RSP) begin
      slave.r_valid = 1'b1;
      slave.r_data  = r_rsp_data;
      slave.r_opc   = r_rsp_opc;
      slave.r_user  = r_rsp_user;
    end else if (r_state == S_ERR) begin
      slave.r_valid = 1'b1;
      slave.r_data  = ERR_WORD;
      slave.r_opc   = 1'b1;
    end
  end

  assign slave.gnt  = (r_state == S_IDLE) && slave.req;
  assign per_req_o  = (r_state == S_REQ);
  assign per_add_o  = r_add;
  assign per_wen_o  = r_wen;
  assign per_data_o = r_data;
  assign per_be_o   = r_be;
  assign per_user_o = r_user;
  assign busy_o     = (r_state != S_IDLE);
  assign timeout_o  = (r_state == S_ERR);

endmodule
